ripple_counter: RTL and testbench

- WIDTH-bit down counter built as a chain of T flip-flop stages with a ripple borrow chain.
- Stage 0 toggles on every enabled clock edge. Stage i toggles when stage 0 toggles and all lower stages are 0. This is the single-clock equivalent of a positive-edge-triggered T-FF down ripple counter.
- Used as a simple event/period down-counter; output is the raw count.

---
 rtl/ripple_counter.sv | 32 +++
 tb/tb_ripple_counter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/ripple_counter.sv
// WIDTH-bit down counter built from T flip-flop stages.
// A ripple borrow chain gates each stage's toggle enable.
module ripple_counter #(
  parameter int WIDTH = 4
) (
  output logic [WIDTH-1:0] Q,
  input  logic             T,
  input  logic             CLK,
  input  logic             RESET
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_t;

  assign w_t[0] = T;

  // Stage i toggles only while every lower stage is zero (borrow).
  for (genvar i = 1; i < WIDTH; i++) begin : g_borrow
    assign w_t[i] = w_t[i-1] & ~r_q[i-1];
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_q <= '0;
    end else begin
      r_q <= r_q ^ w_t;
    end
  end

  assign Q = r_q;

endmodule

// File: tb/tb_ripple_counter.sv
// Directed bench for ripple_counter at WIDTH=4 and WIDTH=6.
// Expected values are hand-computed down-count sequences.
module tb_ripple_counter;

  logic       clk;
  logic       t4;
  logic       rst4;
  logic [3:0] q4;
  logic       t6;
  logic       rst6;
  logic [5:0] q6;

  int n_cmp;
  int n_err;

  ripple_counter #(.WIDTH(4)) u_dut4 (
    .Q(q4), .T(t4), .CLK(clk), .RESET(rst4)
  );

  ripple_counter #(.WIDTH(6)) u_dut6 (
    .Q(q6), .T(t6), .CLK(clk), .RESET(rst6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [3:0] seq5 [5] = '{4'd15, 4'd14, 4'd13, 4'd12, 4'd11};
  logic [15:0] seen;

  initial begin
    n_cmp = 0;
    n_err = 0;
    t4 = 1'b1;
    rst4 = 1'b1;
    t6 = 1'b0;
    rst6 = 1'b1;

    // reset then count
    step(1);
    chk("reset4", 32'(q4), 32'd0);
    rst4 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(1);
      chk("count", 32'(q4), 32'(seq5[k]));
    end

    // reset with T low still clears
    t4 = 1'b0;
    rst4 = 1'b1;
    step(1);
    chk("reset_t0", 32'(q4), 32'd0);

    // full wrap: 17 edges
    rst4 = 1'b0;
    t4 = 1'b1;
    seen = '0;
    for (int k = 1; k <= 16; k++) begin
      step(1);
      chk("wrap_seq", 32'(q4), 32'(16 - k));
      seen[q4] = 1'b1;
    end
    chk("wrap_all", 32'(seen), 32'hFFFF);
    step(1);
    chk("wrap_17", 32'(q4), 32'd15);

    // hold: count 15 -> 9, then T=0
    step(6);
    chk("pre_hold", 32'(q4), 32'd9);
    t4 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk("hold", 32'(q4), 32'd9);
    end
    t4 = 1'b1;
    step(1);
    chk("hold_rel", 32'(q4), 32'd8);

    // mid-count reset at 6
    step(2);
    chk("pre_mid", 32'(q4), 32'd6);
    rst4 = 1'b1;
    step(1);
    chk("mid_rst", 32'(q4), 32'd0);
    rst4 = 1'b0;
    step(1);
    chk("mid_resume", 32'(q4), 32'd15);

    // borrow boundary 8 -> 7
    step(7);
    chk("pre_borrow", 32'(q4), 32'd8);
    step(1);
    chk("borrow", 32'(q4), 32'd7);
    step(7);
    chk("to_zero", 32'(q4), 32'd0);
    step(1);
    chk("zero_wrap", 32'(q4), 32'd15);

    // WIDTH=6
    t6 = 1'b1;
    step(1);
    chk("reset6", 32'(q6), 32'd0);
    rst6 = 1'b0;
    step(1);
    chk("w6_first", 32'(q6), 32'd63);
    step(31);
    chk("w6_mid", 32'(q6), 32'd32);
    step(1);
    chk("w6_borrow", 32'(q6), 32'd31);
    step(31);
    chk("w6_wrap", 32'(q6), 32'd0);
    t6 = 1'b0;
    step(2);
    chk("w6_hold", 32'(q6), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
